// File: rtl/up_down_mon_pkg.sv
// Shared types for the up/down count monitor: FSM states and step classes.
// Also hosts small helpers used by both the classifier and the monitor top.
package up_down_mon_pkg;

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    UP   = 2'd0,
    DN   = 2'd1,
    HOLD = 2'd2,
    ILL  = 2'd3
  } step_e;

  // A legal step that actually moves the count (+1 or -1).
  function automatic logic is_move(input step_e s);
    return (s == UP) || (s == DN);
  endfunction

endpackage : up_down_mon_pkg

// File: rtl/up_down_step_classify.sv
// Combinational step classifier: compares a new count sample against the
// previous reference, modulo 2^W, and flags legal wrap-around steps.
module up_down_step_classify
  import up_down_mon_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] ref_val,
  input  logic [W-1:0] cnt_in,
  output step_e        step,
  output logic         wrap_up,
  output logic         wrap_dn
);

  localparam logic [W-1:0] ONE = W'(1);

  // Sums are held at W bits so the comparison wraps modulo 2^W.
  logic [W-1:0] ref_inc;
  logic [W-1:0] ref_dec;

  assign ref_inc = ref_val + ONE;
  assign ref_dec = ref_val - ONE;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    step = ILL;
    if (cnt_in == ref_val) begin
      step = HOLD;
    end else if (cnt_in == ref_inc) begin
      step = UP;
    end else if (cnt_in == ref_dec) begin
      step = DN;
    end
  end

  assign wrap_up = (step == UP) && (ref_val == '1);
  assign wrap_dn = (step == DN) && (ref_val == '0);

endmodule : up_down_step_classify

// File: rtl/up_down_count_monitor.sv
// Receive-side checker for an up/down counter stream: direction, lock, wraps.
// Optional hold-stall detector is built when HOLD_STALL_EN is defined.
module up_down_count_monitor
  import up_down_mon_pkg::*;
#(
  parameter int W         = 4,
  parameter int LOCK_LEN  = 3,
  parameter int WRAP_W    = 8,
  parameter int STALL_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      cnt_in,
  input  logic              cnt_valid,
  input  logic              clr,
  output logic              dir_up,
  output logic              locked,
  output logic              dir_chg,
  output logic              step_err,
  output logic              err_sticky,
  output logic [WRAP_W-1:0] wrap_cnt
`ifdef HOLD_STALL_EN
  ,
  output logic              stall
`endif
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_LEN);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  state_e             state_q, state_d;
  logic [W-1:0]       ref_q, ref_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               dir_up_q, dir_up_d;
  logic               locked_q, locked_d;
  logic               dir_chg_q, dir_chg_d;
  logic               step_err_q, step_err_d;
  logic               err_sticky_q, err_sticky_d;
  logic [WRAP_W-1:0]  wrap_q, wrap_d;

  step_e              step;
  logic               wrap_up;
  logic               wrap_dn;
  logic               step_is_up;
  logic [RUN_W-1:0]   run_inc;

  up_down_step_classify #(
    .W (W)
  ) u_classify (
    .ref_val (ref_q),
    .cnt_in  (cnt_in),
    .step    (step),
    .wrap_up (wrap_up),
    .wrap_dn (wrap_dn)
  );

  assign step_is_up = (step == UP);
  assign run_inc    = run_q + RUN_ONE;

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    run_d      = run_q;
    dir_up_d   = dir_up_q;
    dir_chg_d  = 1'b0;
    step_err_d = 1'b0;
    wrap_d     = wrap_q;

    if (cnt_valid) begin
      ref_d = cnt_in;
      unique case (state_q)
        ACQ: begin
          run_d   = '0;
          state_d = SYNC;
        end
        SYNC: begin
          if (is_move(step)) begin
            if ((run_q == '0) || (step_is_up == dir_up_q)) begin
              run_d    = run_inc;
              dir_up_d = step_is_up;
              if (run_inc == RUN_LOCK) state_d = LOCK;
            end else begin
              // A reversal before lock restarts the run in the new direction.
              run_d    = RUN_ONE;
              dir_up_d = step_is_up;
            end
          end else if (step == ILL) begin
            step_err_d = 1'b1;
            run_d      = '0;
          end
        end
        LOCK: begin
          if (is_move(step)) begin
            if (step_is_up != dir_up_q) begin
              dir_chg_d = 1'b1;
              dir_up_d  = step_is_up;
            end
          end else if (step == ILL) begin
            step_err_d = 1'b1;
            run_d      = '0;
            state_d    = SYNC;
          end
        end
        default: state_d = ACQ;
      endcase

      // Wrap flags are only raised on legal steps, so ILL never moves the count.
      if (state_q != ACQ) begin
        if (wrap_up) begin
          wrap_d = wrap_q + WRAP_ONE;
        end else if (wrap_dn) begin
          wrap_d = wrap_q - WRAP_ONE;
        end
      end
    end

    // A new error wins over a simultaneous clear.
    err_sticky_d = step_err_d | (err_sticky_q & ~clr);
    locked_d     = (state_d == LOCK);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACQ;
      ref_q        <= '0;
      run_q        <= '0;
      dir_up_q     <= 1'b0;
      locked_q     <= 1'b0;
      dir_chg_q    <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_q       <= '0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      run_q        <= run_d;
      dir_up_q     <= dir_up_d;
      locked_q     <= locked_d;
      dir_chg_q    <= dir_chg_d;
      step_err_q   <= step_err_d;
      err_sticky_q <= err_sticky_d;
      wrap_q       <= wrap_d;
    end
  end

  assign dir_up     = dir_up_q;
  assign locked     = locked_q;
  assign dir_chg    = dir_chg_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;
  assign wrap_cnt   = wrap_q;

`ifdef HOLD_STALL_EN
  localparam int HR_W = $clog2(STALL_LIM + 1);
  localparam logic [HR_W-1:0] HR_ONE = HR_W'(1);
  localparam logic [HR_W-1:0] HR_LIM = HR_W'(STALL_LIM);

  logic [HR_W-1:0] hold_run_q, hold_run_d;
  logic            stall_q, stall_d;
  logic [HR_W-1:0] hold_run_inc;

  assign hold_run_inc = hold_run_q + HR_ONE;

  // Count consecutive holds while locked; saturate at the limit.
  always_comb begin
    hold_run_d = hold_run_q;
    stall_d    = stall_q;
    if (cnt_valid) begin
      if ((state_q == LOCK) && (step == HOLD)) begin
        if (hold_run_q != HR_LIM) begin
          hold_run_d = hold_run_inc;
          if (hold_run_inc == HR_LIM) stall_d = 1'b1;
        end
      end else begin
        hold_run_d = '0;
        stall_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_run_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      hold_run_q <= hold_run_d;
      stall_q    <= stall_d;
    end
  end

  assign stall = stall_q;
`endif

endmodule : up_down_count_monitor

// File: tb/tb_up_down_count_monitor.sv
// Self-checking bench for up_down_count_monitor: directed steps plus a
// randomized stream compared against an arithmetic reference model.
module tb_up_down_count_monitor;

  localparam int W         = 4;
  localparam int LOCK_LEN  = 3;
  localparam int WRAP_W    = 8;
  localparam int STALL_LIM = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [W-1:0]      cnt_in = '0;
  logic              cnt_valid = 1'b0;
  logic              clr = 1'b0;
  logic              dir_up;
  logic              locked;
  logic              dir_chg;
  logic              step_err;
  logic              err_sticky;
  logic [WRAP_W-1:0] wrap_cnt;
`ifdef HOLD_STALL_EN
  logic              stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  up_down_count_monitor #(
    .W         (W),
    .LOCK_LEN  (LOCK_LEN),
    .WRAP_W    (WRAP_W),
    .STALL_LIM (STALL_LIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_valid  (cnt_valid),
    .clr        (clr),
    .dir_up     (dir_up),
    .locked     (locked),
    .dir_chg    (dir_chg),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .wrap_cnt   (wrap_cnt)
`ifdef HOLD_STALL_EN
    ,
    .stall      (stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: integers and modular differences, not an FSM copy.
  bit              m_acquired, m_locked, m_dir, m_dchg, m_serr, m_sticky, m_stall;
  int              m_run, m_holds;
  logic [W-1:0]    m_ref;
  logic [WRAP_W-1:0] m_wrap;

  task automatic model_reset();
    m_acquired = 0; m_locked = 0; m_dir = 0; m_dchg = 0; m_serr = 0;
    m_sticky = 0; m_stall = 0; m_run = 0; m_holds = 0; m_ref = '0; m_wrap = '0;
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] c, input bit cl);
    int d;
    bit up;
    m_dchg = 0;
    m_serr = 0;
    if (v) begin
      d = (int'(c) - int'(m_ref) + (1 << W)) % (1 << W);
      if (!m_acquired) begin
        m_acquired = 1;
        m_run = 0;
      end else if (d == 0) begin
        if (m_locked) begin
          m_holds++;
          if (m_holds >= STALL_LIM) m_stall = 1;
        end else begin
          m_holds = 0;
        end
      end else if (d == 1 || d == (1 << W) - 1) begin
        up = (d == 1);
        if (m_locked) begin
          if (up != m_dir) m_dchg = 1;
        end else if (m_run == 0 || up == m_dir) begin
          m_run++;
          if (m_run == LOCK_LEN) m_locked = 1;
        end else begin
          m_run = 1;
        end
        m_dir = up;
        if (up && m_ref == (1 << W) - 1) m_wrap++;
        if (!up && m_ref == 0) m_wrap--;
        m_holds = 0;
        m_stall = 0;
      end else begin
        m_serr = 1;
        m_run = 0;
        m_locked = 0;
        m_holds = 0;
        m_stall = 0;
      end
      m_ref = c;
    end
    if (m_serr) m_sticky = 1;
    else if (cl) m_sticky = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".locked"},     32'(locked),     32'(m_locked));
    chk({tag, ".dir_up"},     32'(dir_up),     32'(m_dir));
    chk({tag, ".dir_chg"},    32'(dir_chg),    32'(m_dchg));
    chk({tag, ".step_err"},   32'(step_err),   32'(m_serr));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
    chk({tag, ".wrap_cnt"},   32'(wrap_cnt),   32'(m_wrap));
`ifdef HOLD_STALL_EN
    chk({tag, ".stall"},      32'(stall),      32'(m_stall));
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".locked"},     32'(locked),     0);
    chk({tag, ".dir_up"},     32'(dir_up),     0);
    chk({tag, ".dir_chg"},    32'(dir_chg),    0);
    chk({tag, ".step_err"},   32'(step_err),   0);
    chk({tag, ".err_sticky"}, 32'(err_sticky), 0);
    chk({tag, ".wrap_cnt"},   32'(wrap_cnt),   0);
`ifdef HOLD_STALL_EN
    chk({tag, ".stall"},      32'(stall),      0);
`endif
  endtask

  // Drive one sample at the falling edge, check one step after the rising edge.
  task automatic step(input bit v, input logic [W-1:0] c, input bit cl, input string tag);
    @(negedge clk);
    cnt_valid = v;
    cnt_in    = c;
    clr       = cl;
    model_step(v, c, cl);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cnt_valid = 1'b0;
    clr = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] nx;
    int r;
    bit v;

    model_reset();
    #12;
    check_zero("por");
    do_reset();

    // Lock on an upward run.
    for (int i = 0; i <= 3; i++) step(1, W'(i), 0, "acq_up");
    chk("lock_at_3", 32'(locked), 1);
    chk("dir_up_at_3", 32'(dir_up), 1);

    // Upward wrap, then reverse through zero.
    for (int i = 4; i <= 15; i++) step(1, W'(i), 0, "run_up");
    step(1, 4'd0, 0, "wrap_up");
    chk("wrap_plus", 32'(wrap_cnt), 1);
    step(1, 4'd1, 0, "after_wrap");
    step(1, 4'd1, 0, "hold");
    step(1, 4'd0, 0, "reverse");
    chk("dir_chg_pulse", 32'(dir_chg), 1);
    step(1, 4'd15, 0, "wrap_dn");
    chk("wrap_back", 32'(wrap_cnt), 0);
    chk("dir_chg_gone", 32'(dir_chg), 0);

    // Illegal jump while locked, then relock and clear.
    for (int i = 14; i >= 5; i--) step(1, W'(i), 0, "run_dn");
    step(1, 4'd9, 0, "ill_jump");
    chk("ill_err", 32'(step_err), 1);
    chk("ill_unlock", 32'(locked), 0);
    chk("ill_sticky", 32'(err_sticky), 1);
    for (int i = 10; i <= 12; i++) step(1, W'(i), 0, "relock");
    chk("relocked", 32'(locked), 1);
    chk("err_pulse_gone", 32'(step_err), 0);
    step(1, 4'd12, 1, "clr");
    chk("clr_sticky", 32'(err_sticky), 0);
    step(1, 4'd3, 1, "clr_vs_ill");
    chk("set_wins", 32'(err_sticky), 1);

    // Idle input: nothing may move.
    for (int i = 0; i < 10; i++) step(0, W'($urandom_range(0, 15)), 0, "idle");

    // Randomized stream biased toward legal runs.
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 19);
      v  = ($urandom_range(0, 7) != 0);
      if (r < 10)      nx = m_dir ? m_ref + 4'd1 : m_ref - 4'd1;
      else if (r < 13) nx = m_dir ? m_ref - 4'd1 : m_ref + 4'd1;
      else if (r < 18) nx = m_ref;
      else             nx = W'($urandom_range(0, 15));
      step(v, nx, v && ($urandom_range(0, 15) == 0), "rand");
    end

`ifdef HOLD_STALL_EN
    do_reset();
    for (int i = 4; i <= 7; i++) step(1, W'(i), 0, "stall_lock");
    for (int i = 1; i < STALL_LIM; i++) step(1, 4'd7, 0, "hold_run");
    chk("stall_not_yet", 32'(stall), 0);
    step(1, 4'd7, 0, "hold_lim");
    chk("stall_set", 32'(stall), 1);
    step(1, 4'd8, 0, "stall_move");
    chk("stall_clear", 32'(stall), 0);
`endif

    // Asynchronous reset while locked, between clock edges.
    do_reset();
    for (int i = 0; i <= 3; i++) step(1, W'(i), 0, "relock2");
    chk("locked_before_rst", 32'(locked), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cnt_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_up_down_count_monitor
